// File: rtl/inst_fetcher.sv
// Instruction fetch stage: assembles each 32-bit instruction from four byte reads on the
// shared memory port and hands it to the decoder with DecEn/stall handshaking and redirect flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_FETCH | fetchReq=1, issuing byte reads pc+0..pc+3
// ST_DRAIN | all four reads granted, waiting for the final byte
// ST_HOLD  | DecEn=1, instruction held until the decoder consumes it
module inst_fetcher #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   output logic                  DecEn,
   output logic [31:0]           inst,
   output logic [ADDR_WIDTH-1:0] instPC,
   input  logic                  redirectEn,
   input  logic [ADDR_WIDTH-1:0] redirectAddr,
   output logic                  fetchReq,
   output logic [ADDR_WIDTH-1:0] fetchAddr,
   input  logic                  memGrant,
   input  logic [7:0]            memDin
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [1:0]            req_cnt_q, req_cnt_d;
   logic [1:0]            rcv_cnt_q, rcv_cnt_d;
   logic                  dec_en_q, dec_en_d;
   logic [31:0]           inst_q, inst_d;
   logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic                  pend_q, pend_d;
   logic                  kill_q, kill_d;
   logic                  grant_fire;
   logic                  byte_ok;

   assign fetchReq   = (state_q == ST_FETCH);
   assign fetchAddr  = pc_q + ADDR_WIDTH'(req_cnt_q);
   assign grant_fire = fetchReq & memGrant;
   // A byte granted in a redirect cycle still returns next cycle; kill marks it for discard.
   assign byte_ok    = pend_q & ~kill_q;

   assign DecEn  = dec_en_q;
   assign inst   = inst_q;
   assign instPC = inst_pc_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      dec_en_d  = dec_en_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      pend_d    = grant_fire;
      kill_d    = grant_fire & redirectEn;

      if (redirectEn) begin
         pc_d      = redirectAddr;
         req_cnt_d = 2'd0;
         rcv_cnt_d = 2'd0;
         dec_en_d  = 1'b0;
         state_d   = ST_FETCH;
      end else begin
         if (byte_ok) begin
            inst_d[{rcv_cnt_q, 3'b000} +: 8] = memDin;
            rcv_cnt_d = rcv_cnt_q + 2'd1;
         end
         case (state_q)
            ST_FETCH: begin
               if (grant_fire) begin
                  req_cnt_d = req_cnt_q + 2'd1;
                  if (req_cnt_q == 2'd3) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (byte_ok && rcv_cnt_q == 2'd3) begin
                  state_d   = ST_HOLD;
                  dec_en_d  = 1'b1;
                  inst_pc_d = pc_q;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc_d      = pc_q + ADDR_WIDTH'(4);
                  req_cnt_d = 2'd0;
                  rcv_cnt_d = 2'd0;
                  dec_en_d  = 1'b0;
                  state_d   = ST_FETCH;
               end
            end
            default: begin
               state_d   = ST_FETCH;
               req_cnt_d = 2'd0;
               rcv_cnt_d = 2'd0;
               dec_en_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         req_cnt_q <= 2'd0;
         rcv_cnt_q <= 2'd0;
         dec_en_q  <= 1'b0;
         inst_q    <= 32'd0;
         inst_pc_q <= '0;
         pend_q    <= 1'b0;
         kill_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         dec_en_q  <= dec_en_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         pend_q    <= pend_d;
         kill_q    <= kill_d;
      end
   end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed vector table, hand sequences for redirect/wrap/reset,
// and random traffic checked against a transaction-level fetch model.
module tb_inst_fetcher;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        DecEn;
   logic [31:0] inst;
   logic [31:0] instPC;
   logic        redirectEn = 1'b0;
   logic [31:0] redirectAddr = 32'd0;
   logic        fetchReq;
   logic [31:0] fetchAddr;
   logic        memGrant = 1'b0;
   logic [7:0]  memDin = 8'd0;

   int n_chk  = 0;
   int n_fail = 0;

   // model: expected pc, grants seen for the current instruction, cycles until DecEn
   logic [31:0] m_pc;
   int          m_gcnt;
   int          m_wait;

   always #5 clk = ~clk;

   inst_fetcher #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall(stall), .DecEn(DecEn), .inst(inst), .instPC(instPC),
      .redirectEn(redirectEn), .redirectAddr(redirectAddr), .fetchReq(fetchReq),
      .fetchAddr(fetchAddr), .memGrant(memGrant), .memDin(memDin)
   );

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h13;
         32'd1:   return 8'h05;
         32'd2:   return 8'h10;
         32'd3:   return 8'h00;
         default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_gcnt = 0;
      m_wait = 0;
   endtask

   // one clock cycle with the given inputs; model checks before the edge, memory answers after it
   task automatic step(input logic s, input logic g, input logic r, input logic [31:0] ra);
      logic        g_fire;
      logic [31:0] a;
      logic        dec;
      rst = 1'b0; stall = s; memGrant = g; redirectEn = r; redirectAddr = ra;
      #1;
      check("model_fetchReq", {31'd0, fetchReq}, {31'd0, (m_gcnt < 4)});
      if (m_gcnt < 4) check("model_fetchAddr", fetchAddr, m_pc + 32'(m_gcnt));
      check("model_DecEn", {31'd0, DecEn}, {31'd0, (m_gcnt == 4 && m_wait == 0)});
      if (m_gcnt == 4 && m_wait == 0) begin
         check("model_instPC", instPC, m_pc);
         check("model_inst", inst, word_at(m_pc));
      end
      g_fire = fetchReq & g;
      a      = fetchAddr;
      dec    = DecEn;
      @(posedge clk);
      #1;
      memDin = g_fire ? mem_byte(a) : 8'($urandom);
      if (r) begin
         m_pc = ra; m_gcnt = 0; m_wait = 0;
      end else if (dec && !s) begin
         m_pc = m_pc + 32'd4; m_gcnt = 0; m_wait = 0;
      end else if (m_gcnt < 4 && g) begin
         m_gcnt++;
         if (m_gcnt == 4) m_wait = 1;
      end else if (m_wait > 0) begin
         m_wait--;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirectEn = 1'b0; memGrant = 1'b1;
      @(posedge clk);
      #1;
      memDin = 8'($urandom);
      @(posedge clk);
      #1;
      memDin = 8'($urandom);
      check("rst_DecEn", {31'd0, DecEn}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_instPC", instPC, 32'd0);
      check("rst_fetchReq", {31'd0, fetchReq}, 32'd1);
      check("rst_fetchAddr", fetchAddr, 32'h0);
      model_reset();
   endtask

   task automatic run_until_dec(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (DecEn) break;
         step(1'b0, 1'b1, 1'b0, 32'd0);
      end
      check("dec_timeout", {31'd0, DecEn}, 32'd1);
   endtask

   typedef struct {
      logic        s;
      logic        g;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_dec;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [18];

   initial begin
      model_reset();
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 32'd0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 32'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 32'd0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 32'd0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 32'd0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'd5, 1'b0, 32'd0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 32'd6, 1'b0, 32'd0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'd7, 1'b0, 32'd0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd4};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 32'd8, 1'b0, 32'd0};

      // basic fetch, stall hold, and a two-cycle grant gap on byte 1
      do_reset();
      for (int i = 0; i < 18; i++) begin
         check($sformatf("vec%0d_fetchReq", i), {31'd0, fetchReq}, {31'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) check($sformatf("vec%0d_fetchAddr", i), fetchAddr, vecs[i].exp_addr);
         check($sformatf("vec%0d_DecEn", i), {31'd0, DecEn}, {31'd0, vecs[i].exp_dec});
         if (vecs[i].exp_dec) begin
            check($sformatf("vec%0d_instPC", i), instPC, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst", i), inst, word_at(vecs[i].exp_pc));
         end
         if (i == 5) check("first_inst", inst, 32'h00100513);
         step(vecs[i].s, vecs[i].g, 1'b0, 32'd0);
      end

      // redirect in the cycle byte 2 is granted: the late byte must not land in the new word
      do_reset();
      step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h100);
      check("redir_fetchAddr", fetchAddr, 32'h100);
      run_until_dec(20);
      check("redir_instPC", instPC, 32'h100);
      check("redir_inst", inst, word_at(32'h100));

      // redirect while the held instruction is being consumed
      step(1'b0, 1'b1, 1'b1, 32'h200);
      check("redir_consume_DecEn", {31'd0, DecEn}, 32'd0);
      check("redir_consume_fetchAddr", fetchAddr, 32'h200);

      // pc wrap, then reset while draining
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      run_until_dec(20);
      check("wrap_instPC", instPC, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("wrap_fetchAddr", fetchAddr, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
      do_reset();
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check("drain_rst_DecEn", {31'd0, DecEn}, 32'd0);
      run_until_dec(20);
      check("drain_rst_inst", inst, 32'h00100513);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
